// File: rtl/st7920_link_arbiter.sv
// ----------------------------------------------------------------------------
// st7920_link_arbiter
// Shares one ST7920 serial command link between two requesters:
// requester 0 is the bootstrap/config sequencer and requester 1 is the
// framebuffer streamer. Each accepted {rs, byte} word becomes one 24-bit
// serial frame, followed by a fixed idle gap that covers the LCD's command
// execution time. Arbitration is round-robin, with an optional burst lock.
//
// Ports:
//   sys_clk, sys_rst   system clock, synchronous active-high reset
//   req_valid[1:0]     per-requester command valid
//   req_lock[1:0]      per-requester burst lock request (level)
//   req_rs[1:0]        per-requester RS bit (0 = instruction, 1 = data)
//   req_data[15:0]     per-requester byte; requester k uses [8k+7:8k]
//   req_ready[1:0]     per-requester accept (combinational, at most one high)
//   grant[1:0]         one-hot owner of the frame in flight, 00 when idle
//   busy               high while shifting a frame or waiting out the gap
//   lcd_clk            serial clock to the E pin, idles low
//   lcd_data           serial data to the R/W pin
//   lcd_cs             chip select to the RS pin, high during a frame
// ----------------------------------------------------------------------------
module st7920_link_arbiter #(
   parameter int unsigned CLK_DIV  = 256,
   parameter int unsigned GAP_SCLK = 24
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_lock,
   input  logic [1:0]  req_rs,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic        lcd_clk,
   output logic        lcd_data,
   output logic        lcd_cs
);

   localparam int unsigned MAX_SCLK = (GAP_SCLK > 24) ? GAP_SCLK : 24;
   localparam int unsigned CNT_W    = $clog2(2 * CLK_DIV * MAX_SCLK + 1);
   localparam int unsigned GAP_CYC  = GAP_SCLK * 2 * CLK_DIV;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [4:0]       bit_q, bit_d;
   logic [22:0]      shreg_q, shreg_d;   // frame bits still to be presented
   logic             rr_q, rr_d;
   logic             lock_valid_q, lock_valid_d;
   logic             lock_owner_q, lock_owner_d;
   logic [1:0]       grant_q, grant_d;
   logic             busy_q, busy_d;
   logic             lcd_clk_q, lcd_clk_d;
   logic             lcd_data_q, lcd_data_d;
   logic             lcd_cs_q, lcd_cs_d;

   logic             lock_hold_c;
   logic [1:0]       sel_c;
   logic             win_c;
   logic [7:0]       win_byte_c;
   logic [23:0]      frame_c;

   // Eligibility: a held lock restricts selection to the owner; otherwise the
   // rr pointer has priority, then the other requester.
   always_comb begin
      lock_hold_c = lock_valid_q & req_lock[lock_owner_q];
      sel_c       = 2'b00;
      if (lock_hold_c) begin
         sel_c = (2'b01 << lock_owner_q) & req_valid;
      end else if (req_valid[rr_q]) begin
         sel_c = 2'b01 << rr_q;
      end else if (req_valid[~rr_q]) begin
         sel_c = 2'b01 << (~rr_q);
      end
   end

   assign req_ready  = (state_q == S_IDLE && !sys_rst) ? sel_c : 2'b00;
   assign win_c      = req_ready[1];
   assign win_byte_c = win_c ? req_data[15:8] : req_data[7:0];
   assign frame_c    = {5'b11111, 1'b0, req_rs[win_c], 1'b0,
                        win_byte_c[7:4], 4'b0000, win_byte_c[3:0], 4'b0000};

   // Next-state and pin logic.
   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      rr_d         = rr_q;
      lock_valid_d = lock_valid_q;
      lock_owner_d = lock_owner_q;
      grant_d      = grant_q;
      busy_d       = busy_q;
      lcd_clk_d    = lcd_clk_q;
      lcd_data_d   = lcd_data_q;
      lcd_cs_d     = lcd_cs_q;

      case (state_q)
         S_IDLE: begin
            if (!lock_hold_c) lock_valid_d = 1'b0;
            if (|req_ready) begin
               shreg_d      = frame_c[22:0];
               lcd_data_d   = frame_c[23];
               lcd_cs_d     = 1'b1;
               lcd_clk_d    = 1'b0;
               tmr_d        = '0;
               bit_d        = 5'd0;
               rr_d         = ~win_c;
               grant_d      = 2'b01 << win_c;
               lock_valid_d = req_lock[win_c];
               lock_owner_d = win_c;
               busy_d       = 1'b1;
               state_d      = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (tmr_q == DIV_LAST) begin
               tmr_d = '0;
               if (!lcd_clk_q) begin
                  lcd_clk_d = 1'b1;
               end else if (bit_q == 5'd23) begin
                  lcd_clk_d  = 1'b0;
                  lcd_cs_d   = 1'b0;
                  lcd_data_d = 1'b0;
                  grant_d    = 2'b00;
                  state_d    = S_GAP;
               end else begin
                  // Data only moves on the falling edge of lcd_clk.
                  lcd_clk_d  = 1'b0;
                  lcd_data_d = shreg_q[22];
                  shreg_d    = {shreg_q[21:0], 1'b0};
                  bit_d      = bit_q + 5'd1;
               end
            end else begin
               tmr_d = tmr_q + CNT_W'(1);
            end
         end

         S_GAP: begin
            if (32'(tmr_q) + 32'd1 >= GAP_CYC) begin
               tmr_d   = '0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register; reset abandons any frame in flight.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         tmr_q        <= '0;
         bit_q        <= 5'd0;
         shreg_q      <= '0;
         rr_q         <= 1'b0;
         lock_valid_q <= 1'b0;
         lock_owner_q <= 1'b0;
         grant_q      <= 2'b00;
         busy_q       <= 1'b0;
         lcd_clk_q    <= 1'b0;
         lcd_data_q   <= 1'b0;
         lcd_cs_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         rr_q         <= rr_d;
         lock_valid_q <= lock_valid_d;
         lock_owner_q <= lock_owner_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         lcd_clk_q    <= lcd_clk_d;
         lcd_data_q   <= lcd_data_d;
         lcd_cs_q     <= lcd_cs_d;
      end
   end

   assign grant    = grant_q;
   assign busy     = busy_q;
   assign lcd_clk  = lcd_clk_q;
   assign lcd_data = lcd_data_q;
   assign lcd_cs   = lcd_cs_q;

endmodule
